calc1_port_responder: RTL and testbench
=======================================

Name: calc1_port_responder

Overview:
- Four-port calculator responder: the receiving end of the calc1 request/response protocol.
- Accepts a command and two operands on each request port, arbitrates the ports onto one shared ALU and returns a one-cycle response code plus result on the matching output port.
- Serves as a golden-model responder for benches and as a drop-in behavioural replacement for the calculator core in block-level tests.

Parameters:
- ALU_LAT, 3, cycles from ALU issue to result available (1..15)
- DATA_W, 32, operand/result width

Ports:
- c_clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- reqN_cmd_in (N=1..4)  in  4  command: 0 no-op, 1 add, 2 sub, 5 shift left, 6 shift right, others invalid
- reqN_data_in (N=1..4)  in  DATA_W  operand bus
- out_respN (N=1..4)  out  2  0 none, 1 success, 2 overflow/underflow/invalid, 3 never driven
- out_dataN (N=1..4)  out  DATA_W  result, valid only when out_respN is non-zero

Behaviour:
- Reset (reset=0, asynchronous):
  - all out_respN=0, out_dataN=0;
  - port FSMs to IDLE;
  - arbiter pointer to port 1;
  - ALU pipeline flushed.
  - Commands in flight are discarded with no response.
- Per-port FSM: IDLE -> OP2 -> QUEUE -> EXEC -> RESP -> IDLE.
  - IDLE: a non-zero cmd on a rising edge latches cmd and data as op1, then go to OP2. cmd=0 stays in IDLE.
  - OP2: the next edge latches data as op2 unconditionally (cmd ignored), then go to QUEUE.
  - QUEUE: wait for an arbiter grant, then go to EXEC.
  - EXEC: wait ALU_LAT cycles, then go to RESP.
  - RESP: drive out_respN/out_dataN for exactly one cycle, then go to IDLE.
  - Outputs return to 0 the following cycle.
  - A port in OP2, QUEUE, EXEC or RESP ignores all cmd input (protocol: one outstanding command per port). A new command is accepted in the IDLE cycle immediately after RESP.
- Arbiter:
  - Round-robin over ports in QUEUE, at most one grant per cycle.
  - Search starts at the port after the last granted port.
  - Pointer updates only on a grant.
  - Worst-case wait is 3 grants.
- ALU issues the granted operation and is pipelined: one issue per cycle, ALU_LAT stage delay line carrying result, resp and port id.
- Arithmetic (unsigned, DATA_W bits):
  - add: carry out of the MSB -> resp 2, data 0; else resp 1, data op1+op2.
  - sub: op2>op1 -> resp 2, data 0; else resp 1, data op1-op2. op1==op2 gives resp 1, data 0.
  - shl/shr: shift amount = op2[4:0] (low 5 bits), zero fill, resp 1. Amount 0 returns op1 unchanged. Upper op2 bits are ignored.
  - invalid cmd (3,4,7..15): still consumes op2, queues and passes through the ALU; resp 2, data 0.
- Latency from the op1 edge to the response cycle = 2 + arbitration wait + ALU_LAT. Uncontended with ALU_LAT=3: response in cycle 5 after the op1 edge.
- Simultaneous events:
  - Several ports may reach RESP in different cycles only; the pipeline guarantees at most one response per cycle in total.
  - A port entering QUEUE in the same cycle another port is granted waits its turn.
  - Reset asserted mid-operation aborts everything immediately; after deassertion the first edge may accept a new op1.

Test Plan:
1. Port1: cmd=1, data=0x00000005 then 0x00000007, ALU_LAT=3 -> out_resp1=1, out_data1=0x0000000C exactly 5 cycles after op1, for one cycle only.
2. Port2: add 0xFFFFFFFF+0x00000001 -> resp 2, data 0. Sub 0x00000003-0x00000004 -> resp 2. Sub 0x00000004-0x00000004 -> resp 1, data 0.
3. Port3: shl 0x00000001 by op2=0x00000021 -> resp 1, data 0x00000002 (amount 1). Shr 0x80000000 by 31 -> resp 1, data 0x00000001.
4. All four ports issue add on the same edge, pointer at port 1 -> responses on ports 1,2,3,4 in consecutive cycles, each with the correct sum. A following burst is served starting at port 1.
5. Port4: cmd=9 -> resp 2, data 0 at normal latency. A cmd=1 presented while port 4 is in EXEC is ignored (no second response).
6. Reset pulled low while port1 is in EXEC and port2 is in QUEUE -> all outputs 0 immediately, no late responses appear. A fresh add after reset release completes normally.

Source files
------------

// File: rtl/calc1_port_responder.sv
// calc1_port_responder
//   Receiving end of the calc1 request/response protocol. Four request ports
//   each run a small FSM (op1, op2, queue, execute, respond). Queued ports are
//   served round-robin by one shared, pipelined ALU. Each port gets a
//   one-cycle response code and result on its own output pair.
//
//   Ports
//     c_clk                 clock, rising edge
//     reset                 asynchronous reset, active low
//     reqN_cmd_in  [3:0]    command (0 nop, 1 add, 2 sub, 5 shl, 6 shr, others invalid)
//     reqN_data_in [W-1:0]  operand bus (op1 on the command edge, op2 on the next)
//     out_respN    [1:0]    0 none, 1 success, 2 overflow/underflow/invalid
//     out_dataN    [W-1:0]  result, zero whenever out_respN is zero
//
//   state    | meaning
//   ST_IDLE  | waiting for a non-zero command; latches cmd and op1
//   ST_OP2   | latches op2 on the next edge, cmd ignored
//   ST_QUEUE | waiting for an arbiter grant
//   ST_EXEC  | operation in the ALU pipeline
//   ST_RESP  | response driven on the port outputs for this cycle
module calc1_port_responder #(
  parameter int ALU_LAT = 3,
  parameter int DATA_W  = 32
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req1_cmd_in,
  input  logic [3:0]        req2_cmd_in,
  input  logic [3:0]        req3_cmd_in,
  input  logic [3:0]        req4_cmd_in,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic [DATA_W-1:0] req2_data_in,
  input  logic [DATA_W-1:0] req3_data_in,
  input  logic [DATA_W-1:0] req4_data_in,
  output logic [1:0]        out_resp1,
  output logic [1:0]        out_resp2,
  output logic [1:0]        out_resp3,
  output logic [1:0]        out_resp4,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic [DATA_W-1:0] out_data4
);

  localparam int LAST = ALU_LAT - 1;

  typedef enum logic [2:0] {ST_IDLE, ST_OP2, ST_QUEUE, ST_EXEC, ST_RESP} state_t;

  logic [3:0]        cmd_in  [4];
  logic [DATA_W-1:0] data_in [4];

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  state_t            state_q [4];
  state_t            state_d [4];
  logic [3:0]        cmd_q   [4];
  logic [DATA_W-1:0] op1_q   [4];
  logic [DATA_W-1:0] op2_q   [4];

  logic [1:0] rr_q;      // first port examined by the next arbitration
  logic       grant_vld;
  logic [1:0] grant_id;
  logic [1:0] arb_idx;

  logic              pipe_vld  [ALU_LAT];
  logic [1:0]        pipe_id   [ALU_LAT];
  logic [1:0]        pipe_resp [ALU_LAT];
  logic [DATA_W-1:0] pipe_data [ALU_LAT];

  logic [DATA_W-1:0] alu_a, alu_b;
  logic [DATA_W:0]   alu_sum;
  logic [1:0]        alu_resp;
  logic [DATA_W-1:0] alu_data;

  logic [3:0]        done;
  logic [1:0]        resp_q [4];
  logic [DATA_W-1:0] data_q [4];

  // Round-robin: first queued port at or after rr_q wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = rr_q;
    arb_idx   = rr_q;
    for (int i = 0; i < 4; i++) begin
      arb_idx = rr_q + 2'(i);
      if (!grant_vld && state_q[arb_idx] == ST_QUEUE) begin
        grant_vld = 1'b1;
        grant_id  = arb_idx;
      end
    end
  end

  always_comb begin
    alu_a    = op1_q[grant_id];
    alu_b    = op2_q[grant_id];
    alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
    alu_resp = 2'd2;
    alu_data = '0;
    case (cmd_q[grant_id])
      4'd1: if (!alu_sum[DATA_W]) begin
        alu_resp = 2'd1;
        alu_data = alu_sum[DATA_W-1:0];
      end
      4'd2: if (alu_a >= alu_b) begin
        alu_resp = 2'd1;
        alu_data = alu_a - alu_b;
      end
      4'd5: begin
        alu_resp = 2'd1;
        alu_data = alu_a << alu_b[4:0];
      end
      4'd6: begin
        alu_resp = 2'd1;
        alu_data = alu_a >> alu_b[4:0];
      end
      default: ;
    endcase
  end

  // A port's operation leaves the pipeline; it responds on the same edge.
  always_comb begin
    done = '0;
    for (int p = 0; p < 4; p++)
      done[p] = pipe_vld[LAST] && (pipe_id[LAST] == 2'(p));
  end

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      state_d[p] = state_q[p];
      case (state_q[p])
        ST_IDLE:  if (cmd_in[p] != 4'd0) state_d[p] = ST_OP2;
        ST_OP2:   state_d[p] = ST_QUEUE;
        ST_QUEUE: if (grant_vld && grant_id == 2'(p)) state_d[p] = ST_EXEC;
        ST_EXEC:  if (done[p]) state_d[p] = ST_RESP;
        ST_RESP:  state_d[p] = ST_IDLE;
        default:  state_d[p] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < 4; p++) state_q[p] <= ST_IDLE;
    end else begin
      for (int p = 0; p < 4; p++) state_q[p] <= state_d[p];
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      rr_q <= 2'd0;
      for (int p = 0; p < 4; p++) begin
        cmd_q[p]  <= '0;
        op1_q[p]  <= '0;
        op2_q[p]  <= '0;
        resp_q[p] <= '0;
        data_q[p] <= '0;
      end
      for (int i = 0; i < ALU_LAT; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_id[i]   <= '0;
        pipe_resp[i] <= '0;
        pipe_data[i] <= '0;
      end
    end else begin
      if (grant_vld) rr_q <= grant_id + 2'd1;
      pipe_vld[0]  <= grant_vld;
      pipe_id[0]   <= grant_id;
      pipe_resp[0] <= alu_resp;
      pipe_data[0] <= alu_data;
      for (int i = 1; i < ALU_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_id[i]   <= pipe_id[i-1];
        pipe_resp[i] <= pipe_resp[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
      for (int p = 0; p < 4; p++) begin
        if (state_q[p] == ST_IDLE && cmd_in[p] != 4'd0) begin
          cmd_q[p] <= cmd_in[p];
          op1_q[p] <= data_in[p];
        end
        if (state_q[p] == ST_OP2) op2_q[p] <= data_in[p];
        resp_q[p] <= done[p] ? pipe_resp[LAST] : 2'd0;
        data_q[p] <= done[p] ? pipe_data[LAST] : '0;
      end
    end
  end

  assign out_resp1 = resp_q[0];
  assign out_resp2 = resp_q[1];
  assign out_resp3 = resp_q[2];
  assign out_resp4 = resp_q[3];
  assign out_data1 = data_q[0];
  assign out_data2 = data_q[1];
  assign out_data3 = data_q[2];
  assign out_data4 = data_q[3];

endmodule

// File: tb/tb_calc1_port_responder.sv
// Testbench for calc1_port_responder: directed vector table, round-robin
// bursts, ignored-command and reset-abort sequences, and randomized single
// operations checked against an arithmetic reference model.
module tb_calc1_port_responder;

  localparam int DW = 32;

  logic c_clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0][3:0]    cmd = '0;
  logic [3:0][DW-1:0] dat = '0;

  logic [1:0]    out_resp1, out_resp2, out_resp3, out_resp4;
  logic [DW-1:0] out_data1, out_data2, out_data3, out_data4;
  logic [1:0]    rsp  [4];
  logic [DW-1:0] odat [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 c_clk = ~c_clk;

  always_comb begin
    rsp[0] = out_resp1; rsp[1] = out_resp2; rsp[2] = out_resp3; rsp[3] = out_resp4;
    odat[0] = out_data1; odat[1] = out_data2; odat[2] = out_data3; odat[3] = out_data4;
  end

  calc1_port_responder #(.ALU_LAT(3), .DATA_W(DW)) dut (
    .c_clk(c_clk), .reset(reset),
    .req1_cmd_in(cmd[0]), .req2_cmd_in(cmd[1]), .req3_cmd_in(cmd[2]), .req4_cmd_in(cmd[3]),
    .req1_data_in(dat[0]), .req2_data_in(dat[1]), .req3_data_in(dat[2]), .req4_data_in(dat[3]),
    .out_resp1(out_resp1), .out_resp2(out_resp2), .out_resp3(out_resp3), .out_resp4(out_resp4),
    .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3), .out_data4(out_data4)
  );

  typedef struct {
    int         port;
    logic [3:0] cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0] er;
    logic [31:0] ed;
    string      name;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Unsigned calculator semantics in plain integer arithmetic.
  function automatic void ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [1:0] r, output logic [31:0] d);
    longint unsigned s;
    int amt;
    amt = int'(b % 32);
    r = 2'd2;
    d = 32'd0;
    case (c)
      4'd1: begin
        s = longint'(a) + longint'(b);
        if (s < 64'h1_0000_0000) begin r = 2'd1; d = 32'(s); end
      end
      4'd2: if (a >= b) begin r = 2'd1; d = a - b; end
      4'd5: begin s = longint'(a) * (longint'(1) << amt); r = 2'd1; d = 32'(s); end
      4'd6: begin r = 2'd1; d = a / (32'd1 << amt); end
      default: ;
    endcase
  endfunction

  // One uncontended operation; response must appear 5 edges after op1, for one cycle.
  task automatic send_and_check(input int p, input logic [3:0] c, input logic [31:0] a,
                                input logic [31:0] b, input logic [1:0] er, input logic [31:0] ed,
                                input string name);
    int k;
    int hit;
    @(negedge c_clk); cmd[p] = c;    dat[p] = a;
    @(negedge c_clk); cmd[p] = 4'd0; dat[p] = b;
    @(negedge c_clk); dat[p] = '0;
    hit = -1;
    k = 1;
    while (hit < 0 && k < 30) begin
      @(negedge c_clk);
      k++;
      for (int q = 0; q < 4; q++) if (hit < 0 && rsp[q] != 2'd0) hit = q;
    end
    check({name, "_port"}, 64'(hit), 64'(p));
    check({name, "_lat"}, 64'(k), 64'(5));
    if (hit >= 0) begin
      check({name, "_resp"}, 64'(rsp[hit]), 64'(er));
      check({name, "_data"}, 64'(odat[hit]), 64'(ed));
    end
    @(negedge c_clk);
    check({name, "_onecycle"}, 64'(rsp[p]), 64'(0));
  endtask

  // All four ports issue add on the same edge; round-robin order from st.
  task automatic burst(input int st, input string name);
    logic [31:0] a [4];
    logic [31:0] b [4];
    int          lat [4];
    logic [1:0]  gr [4];
    logic [31:0] gd [4];
    logic [1:0]  er;
    logic [31:0] ed;
    int          extra;
    int          per_cyc;
    for (int q = 0; q < 4; q++) begin
      a[q] = $urandom_range(0, 32'h7FFF_FFFF);
      b[q] = $urandom_range(0, 32'h7FFF_FFFF);
      lat[q] = -1;
      gr[q] = 2'd0;
      gd[q] = 32'd0;
    end
    @(negedge c_clk); for (int q = 0; q < 4; q++) begin cmd[q] = 4'd1; dat[q] = a[q]; end
    @(negedge c_clk); for (int q = 0; q < 4; q++) begin cmd[q] = 4'd0; dat[q] = b[q]; end
    @(negedge c_clk); for (int q = 0; q < 4; q++) dat[q] = '0;
    extra = 0;
    for (int k = 2; k <= 20; k++) begin
      @(negedge c_clk);
      per_cyc = 0;
      for (int q = 0; q < 4; q++) begin
        if (rsp[q] != 2'd0) begin
          per_cyc++;
          if (lat[q] < 0) begin lat[q] = k; gr[q] = rsp[q]; gd[q] = odat[q]; end
          else extra++;
        end
      end
      if (per_cyc > 1) extra++;
    end
    check({name, "_extra"}, 64'(extra), 64'(0));
    for (int q = 0; q < 4; q++) begin
      ref_alu(4'd1, a[q], b[q], er, ed);
      check($sformatf("%s_p%0d_lat", name, q + 1), 64'(lat[q]), 64'(5 + ((q - st + 4) % 4)));
      check($sformatf("%s_p%0d_resp", name, q + 1), 64'(gr[q]), 64'(er));
      check($sformatf("%s_p%0d_data", name, q + 1), 64'(gd[q]), 64'(ed));
    end
  endtask

  task automatic expect_quiet(input int cycles, input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge c_clk);
      for (int q = 0; q < 4; q++) if (rsp[q] != 2'd0 || odat[q] != '0) seen++;
    end
    check({name, "_quiet"}, 64'(seen), 64'(0));
  endtask

  task automatic reset_pulse();
    @(negedge c_clk); reset = 1'b0;
    @(negedge c_clk);
    @(negedge c_clk); reset = 1'b1;
  endtask

  vec_t vt [11];

  initial begin
    logic [3:0]  rc;
    logic [31:0] ra, rb, ed;
    logic [1:0]  er;
    int          rp, hit, cnt, kfirst;
    logic [1:0]  rfirst;
    logic [31:0] dfirst;

    vt[0]  = '{0, 4'd1, 32'h0000_0005, 32'h0000_0007, 2'd1, 32'h0000_000C, "add_5_7"};
    vt[1]  = '{1, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0,         "add_carry"};
    vt[2]  = '{1, 4'd2, 32'h0000_0003, 32'h0000_0004, 2'd2, 32'h0,         "sub_under"};
    vt[3]  = '{1, 4'd2, 32'h0000_0004, 32'h0000_0004, 2'd1, 32'h0,         "sub_equal"};
    vt[4]  = '{2, 4'd5, 32'h0000_0001, 32'h0000_0021, 2'd1, 32'h0000_0002, "shl_wrap_amt"};
    vt[5]  = '{2, 4'd6, 32'h8000_0000, 32'd31,        2'd1, 32'h0000_0001, "shr_31"};
    vt[6]  = '{3, 4'd9, 32'h1234_5678, 32'h9ABC_DEF0, 2'd2, 32'h0,         "invalid_9"};
    vt[7]  = '{0, 4'd5, 32'h0000_ABCD, 32'hFFFF_FFE0, 2'd1, 32'h0000_ABCD, "shl_amt0"};
    vt[8]  = '{3, 4'd2, 32'd10,        32'd3,         2'd1, 32'd7,         "sub_10_3"};
    vt[9]  = '{0, 4'd3, 32'd1,         32'd2,         2'd2, 32'h0,         "invalid_3"};
    vt[10] = '{1, 4'd1, 32'h7FFF_FFFF, 32'h8000_0000, 2'd1, 32'hFFFF_FFFF, "add_max"};

    @(negedge c_clk);
    @(negedge c_clk);
    for (int q = 0; q < 4; q++) begin
      check($sformatf("rst_resp%0d", q + 1), 64'(rsp[q]), 64'(0));
      check($sformatf("rst_data%0d", q + 1), 64'(odat[q]), 64'(0));
    end
    reset = 1'b1;

    for (int i = 0; i < 11; i++)
      send_and_check(vt[i].port, vt[i].cmd, vt[i].a, vt[i].b, vt[i].er, vt[i].ed, vt[i].name);

    // Pointer back at port 1, then a second burst that must also start at port 1.
    reset_pulse();
    burst(0, "burst1");
    burst(0, "burst2");

    // Command presented on port 4 while it is executing must be ignored.
    @(negedge c_clk); cmd[3] = 4'd9; dat[3] = 32'h0000_0011;
    @(negedge c_clk); cmd[3] = 4'd0; dat[3] = 32'h0000_0022;
    @(negedge c_clk); dat[3] = '0;
    @(negedge c_clk); cmd[3] = 4'd1; dat[3] = 32'h0000_0010;
    cnt = 0; kfirst = -1; hit = -1; rfirst = 2'd0; dfirst = '0;
    for (int k = 3; k <= 25; k++) begin
      @(negedge c_clk);
      if (k == 5) begin cmd[3] = 4'd0; dat[3] = '0; end
      for (int q = 0; q < 4; q++) begin
        if (rsp[q] != 2'd0) begin
          cnt++;
          if (hit < 0) begin hit = q; kfirst = k; rfirst = rsp[q]; dfirst = odat[q]; end
        end
      end
    end
    check("busy_ignore_count", 64'(cnt), 64'(1));
    check("busy_ignore_port", 64'(hit), 64'(3));
    check("busy_ignore_lat", 64'(kfirst), 64'(5));
    check("busy_ignore_resp", 64'(rfirst), 64'(2));
    check("busy_ignore_data", 64'(dfirst), 64'(0));

    // Reset while port 1 executes and port 2 is queued.
    @(negedge c_clk); cmd[0] = 4'd1; dat[0] = 32'd100;
    @(negedge c_clk); cmd[0] = 4'd0; dat[0] = 32'd200; cmd[1] = 4'd1; dat[1] = 32'd300;
    @(negedge c_clk); dat[0] = '0;   cmd[1] = 4'd0; dat[1] = 32'd400;
    @(negedge c_clk); dat[1] = '0;
    #1 reset = 1'b0;
    #1;
    for (int q = 0; q < 4; q++) check($sformatf("abort_resp%0d", q + 1), 64'(rsp[q]), 64'(0));
    @(negedge c_clk);
    @(negedge c_clk); reset = 1'b1;
    expect_quiet(15, "abort");
    send_and_check(0, 4'd1, 32'd1000, 32'd234, 2'd1, 32'd1234, "after_abort");

    // Reset while a response is on the outputs clears them without a clock edge.
    @(negedge c_clk); cmd[2] = 4'd1; dat[2] = 32'd40;
    @(negedge c_clk); cmd[2] = 4'd0; dat[2] = 32'd2;
    @(negedge c_clk); dat[2] = '0;
    hit = 0;
    for (int k = 0; k < 20 && hit == 0; k++) begin
      @(negedge c_clk);
      if (rsp[2] != 2'd0) hit = 1;
    end
    check("live_resp_seen", 64'(hit), 64'(1));
    #2 reset = 1'b0;
    #1;
    check("live_resp_cleared", 64'(rsp[2]), 64'(0));
    check("live_data_cleared", 64'(odat[2]), 64'(0));
    @(negedge c_clk); reset = 1'b1;
    expect_quiet(8, "live_abort");

    // Randomized single operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rp = $urandom_range(0, 3);
      case ($urandom_range(0, 9))
        0, 1:    rc = 4'd1;
        2, 3:    rc = 4'd2;
        4, 5:    rc = 4'd5;
        6, 7:    rc = 4'd6;
        8:       rc = 4'd3;
        default: rc = 4'(11 + $urandom_range(0, 4));
      endcase
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
      ref_alu(rc, ra, rb, er, ed);
      send_and_check(rp, rc, ra, rb, er, ed, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
